md_sched: RTL and testbench

// - Sequences the multi-cycle multiply/divide resource and owns the architectural HI/LO registers.
// - Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per issue from the EX stage and times the busy window.
// - Asserts md_stall, which the hazard unit ORs into stall to freeze F/D and clear E, while a D-stage HI/LO user collides with it.

---
 rtl/md_sched_pkg.sv | 26 ++
 rtl/md_sched_calc.sv | 57 +++++
 rtl/md_sched.sv | 100 ++++++++++
 tb/tb_md_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared op codes, FSM state codes and default latencies for the mult/div scheduler.
package md_sched_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_calc.sv
// Combinational 32x32 multiply / divide datapath; results are latched by md_sched at issue.
module md_calc
  import md_sched_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Divisor is forced to 1 for the zero and INT_MIN/-1 cases so the dividers never see them.
  assign div0   = (src_b == 32'd0);
  assign ovf    = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign b_safe = (div0 || ovf) ? 32'd1 : src_b;
  assign quo_s  = $signed(src_a) / $signed(b_safe);
  assign rem_s  = $signed(src_a) % $signed(b_safe);
  assign quo_u  = src_a / b_safe;
  assign rem_u  = src_a % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (ovf) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = quo_s;
          res_hi = rem_s;
        end
      end
      MD_DIVU: begin
        res_lo = quo_u;
        res_hi = rem_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler: times the busy window, owns HI/LO and raises md_stall.
//   state   | meaning
//   ST_IDLE | no op in flight; MTHI/MTLO write directly, MULT/DIV launch
//   ST_RUN  | result held in pend regs, cnt counts down to commit
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_div0;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div0;

  md_calc u_calc (
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign busy     = (state == ST_RUN);
  assign md_stall = md_use_D & (start | busy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_div0 <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul(md_op)) begin
              pend_hi   <= res_hi;
              pend_lo   <= res_lo;
              pend_div0 <= 1'b0;
              cnt       <= CNT_W'(MULT_CYC - 1);
              state     <= ST_RUN;
            end else if (is_div(md_op)) begin
              pend_hi   <= res_hi;
              pend_lo   <= res_lo;
              pend_div0 <= div0;
              cnt       <= CNT_W'(DIV_CYC - 1);
              state     <= ST_RUN;
            end else if (md_op == MD_MTHI) begin
              hi <= src_a;
            end else if (md_op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        ST_RUN: begin
          // A divide by zero still runs the full window but leaves HI/LO untouched.
          if (cnt == '0) begin
            if (!pend_div0) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, corner sequences and random ops vs a reference model.
module tb_md_sched;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int LAT_MUL = 5;
  localparam int LAT_DIV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: products in 64-bit arithmetic, division on magnitudes with signs applied afterwards.
  task automatic ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output logic z);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    rh = m_hi; rl = m_lo; z = 1'b0;
    if (op == OP_MULT) begin
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
      rh = p[63:32]; rl = p[31:0];
    end else if (op == OP_MULTU) begin
      p = 64'(a) * 64'(b);
      rh = p[63:32]; rl = p[31:0];
    end else if (b == 32'd0) begin
      z = 1'b1;
    end else if (op == OP_DIVU) begin
      rl = a / b; rh = a % b;
    end else begin
      na = a[31]; nb = b[31];
      ma = na ? -a : a;
      mb = nb ? -b : b;
      q = ma / mb; r = ma % mb;
      rl = (na ^ nb) ? -q : q;
      rh = na ? -r : r;
    end
  endtask

  // Issues a long op in cycle 0 and follows it through commit; poke>0 fires an extra start in that busy cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input int poke);
    int n;
    logic bad_busy;
    n = 0;
    bad_busy = 1'b0;
    start = 1'b1; md_op = op; src_a = a; src_b = b; md_use_D = use_d;
    #1;
    chk({name, " c0 stall"}, 64'(md_stall), 64'(use_d));
    chk({name, " c0 busy"}, 64'(busy), 64'd0);
    tick();
    start = 1'b0; md_op = OP_NONE; src_a = 32'd0; src_b = 32'd0;
    #1;
    while (busy && n < 40) begin
      if (poke != 0 && n + 1 == poke) begin
        start = 1'b1; md_op = OP_MULT; src_a = 32'd5; src_b = 32'd5;
      end else begin
        start = 1'b0; md_op = OP_NONE;
      end
      #1;
      if (md_stall !== use_d || done !== 1'b0) bad_busy = 1'b1;
      tick();
      n++;
    end
    start = 1'b0; md_op = OP_NONE;
    #1;
    chk({name, " busy window"}, 64'(bad_busy), 64'd0);
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    chk({name, " stall after"}, 64'(md_stall), 64'd0);
    tick();
    chk({name, " done clear"}, 64'(done), 64'd0);
    m_hi = eh; m_lo = el;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; md_op = op; src_a = a; md_use_D = 1'b0;
    tick();
    start = 1'b0; md_op = OP_NONE;
    if (op == OP_MTHI) m_hi = a; else m_lo = a;
  endtask

  initial begin
    logic [31:0] rh, rl;
    logic        z;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          lat;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT_MUL};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        1'b0, 32'h0000_0002, 32'hFFFF_FFFA, LAT_MUL};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV};
    vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, LAT_DIV};
    vecs[4] = '{OP_DIVU,  32'd100,       32'd7,        1'b1, 32'h0000_0002, 32'h0000_000E, LAT_DIV};
    vecs[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, LAT_DIV};
    vecs[6] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001, LAT_MUL};
    vecs[7] = '{OP_MULTU, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, LAT_MUL};

    reset = 1'b0; start = 1'b0; md_op = OP_NONE; src_a = 32'd0; src_b = 32'd0; md_use_D = 1'b0;
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    md_use_D = 1'b1;
    #1;
    chk("reset stall", 64'(md_stall), 64'd0);
    md_use_D = 1'b0;
    reset = 1'b1;
    tick();

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat, 0);

    // Back-to-back MTHI/MTLO
    start = 1'b1; md_op = OP_MTHI; src_a = 32'h1234; md_use_D = 1'b0;
    tick();
    md_op = OP_MTLO; src_a = 32'h5678;
    #1;
    chk("mt busy mid", 64'(busy), 64'd0);
    tick();
    start = 1'b0; md_op = OP_NONE;
    #1;
    chk("mt hi", 64'(hi), 64'h1234);
    chk("mt lo", 64'(lo), 64'h5678);
    chk("mt busy", 64'(busy), 64'd0);
    chk("mt done", 64'(done), 64'd0);
    m_hi = 32'h1234; m_lo = 32'h5678;

    // Divide by zero keeps prior HI/LO
    do_mt(OP_MTHI, 32'h11);
    do_mt(OP_MTLO, 32'h22);
    run_op("divu0", OP_DIVU, 32'd55, 32'd0, 1'b0, 32'h11, 32'h22, LAT_DIV, 0);
    run_op("div0", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b1, 32'h11, 32'h22, LAT_DIV, 0);

    // Start during busy is ignored
    run_op("intrude", OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, LAT_DIV, 3);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (op == OP_MTHI || op == OP_MTLO) begin
        do_mt(op, a);
        #1;
        chk($sformatf("rnd%0d mt hi", k), 64'(hi), 64'(m_hi));
        chk($sformatf("rnd%0d mt lo", k), 64'(lo), 64'(m_lo));
      end else begin
        ref_calc(op, a, b, rh, rl, z);
        lat = (op == OP_MULT || op == OP_MULTU) ? LAT_MUL : LAT_DIV;
        run_op($sformatf("rnd%0d op%0d", k, op), op, a, b, 1'($urandom_range(0, 1)), rh, rl, lat, 0);
      end
    end

    // Reset mid-run aborts the op
    do_mt(OP_MTHI, 32'hABCD);
    start = 1'b1; md_op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    tick();
    start = 1'b0; md_op = OP_NONE;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'd0) begin
        chk($sformatf("postrst c%0d busy/done/lo", k), {busy, done, lo}, 34'd0);
      end
    end
    chk("postrst idle", {30'd0, busy, done, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
